// File: rtl/uart_word_loader.sv
`timescale 1ns/1ps
// Packs bytes popped from the UART RX FIFO into words and writes them to consecutive
// addresses over a valid/ready port, with optional inter-byte timeout and restart.
module uart_word_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int BYTES_PER_WORD = 2,
  parameter int FIRST_BYTE_LSB = 1,
  parameter int BASE_ADDR      = 0,
  parameter int WORD_COUNT     = 2**ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_empty,
  input  logic [7:0]                  rx_data,
  output logic                        rd_uart,
  output logic                        wr_valid,
  input  logic                        wr_ready,
  output logic [ADDR_WIDTH-1:0]       wr_addr,
  output logic [8*BYTES_PER_WORD-1:0] wr_data,
  input  logic                        clear,
  output logic                        done,
  output logic                        overflow,
  output logic                        frame_err
);

  localparam int CNT_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST      = ADDR_WIDTH'(BASE_ADDR + WORD_COUNT - 1);
  localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [IDLE_W-1:0]     IDLE_LAST = IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {COLLECT, WRITE, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        byte_cnt, byte_cnt_nxt;
  logic [IDLE_W-1:0]       idle_cnt, idle_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic                    overflow_nxt;
  logic                    frame_err_nxt;
  logic                    pop;
  logic [CNT_W-1:0]        slot;

  assign pop      = (state == COLLECT || state == DONE) && !rx_empty && !clear;
  assign rd_uart  = pop && rst_n;
  assign wr_valid = (state == WRITE);
  assign done     = (state == DONE);
  assign slot     = (FIRST_BYTE_LSB != 0) ? byte_cnt : LAST_BYTE - byte_cnt;

  always_comb begin
    state_nxt     = state;
    byte_cnt_nxt  = byte_cnt;
    idle_nxt      = idle_cnt;
    addr_nxt      = wr_addr;
    overflow_nxt  = overflow;
    frame_err_nxt = 1'b0;
    if (clear) begin
      state_nxt    = COLLECT;
      byte_cnt_nxt = '0;
      idle_nxt     = '0;
      addr_nxt     = BASE;
      overflow_nxt = 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (pop) begin
            idle_nxt = '0;
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt_nxt = '0;
              state_nxt    = WRITE;
            end else begin
              byte_cnt_nxt = byte_cnt + CNT_W'(1);
            end
          end else if (TIMEOUT_CYCLES > 0 && byte_cnt != '0) begin
            // A pop in the expiry cycle takes the branch above, so it always wins.
            if (idle_cnt == IDLE_LAST) begin
              byte_cnt_nxt  = '0;
              idle_nxt      = '0;
              frame_err_nxt = 1'b1;
            end else begin
              idle_nxt = idle_cnt + IDLE_W'(1);
            end
          end else begin
            idle_nxt = '0;
          end
        end
        WRITE: begin
          if (wr_ready) begin
            if (wr_addr == LAST) begin
              state_nxt = DONE;
            end else begin
              addr_nxt  = wr_addr + ADDR_WIDTH'(1);
              state_nxt = COLLECT;
            end
          end
        end
        DONE: begin
          if (pop) overflow_nxt = 1'b1;
        end
        default: state_nxt = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      byte_cnt  <= '0;
      idle_cnt  <= '0;
      wr_addr   <= BASE;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      byte_cnt  <= byte_cnt_nxt;
      idle_cnt  <= idle_nxt;
      wr_addr   <= addr_nxt;
      overflow  <= overflow_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  // Word register doubles as the write-data output; slots are overwritten byte by byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_data <= '0;
    end else if (state == COLLECT && pop) begin
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
        if (slot == CNT_W'(i)) wr_data[8*i +: 8] <= rx_data;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_loader.sv
`timescale 1ns/1ps
// Bench for uart_word_loader: four parameterisations driven from byte-level FIFO models,
// with a word-level scoreboard checked on every write handshake.
module tb_uart_word_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rx_empty, rd, wv, wrdy, clr, dn, ovf, ferr;
  logic [7:0]  rx_data [4];
  logic [7:0]  wa [4];
  logic [15:0] wd0, wd2, wd3;
  logic [31:0] wd1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  fifo  [4][$];
  logic [71:0] exp_q [4][$];
  logic [71:0] got_q [4][$];
  int          ferr_cnt [4];
  int          pops [4];
  logic [3:0]  will_pop;

  logic [7:0]  m_addr [4];
  logic [63:0] m_acc [4];
  int          m_n [4];
  int          m_words [4];

  logic [3:0]  pstall;
  logic [7:0]  pa [4];
  logic [63:0] pd [4];

  // DUT 0: defaults; 1: 4-byte MSB-first; 2: two words from FF; 3: 16-cycle timeout
  uart_word_loader u0 (
    .clk(clk), .rst_n(rst_n), .rx_empty(rx_empty[0]), .rx_data(rx_data[0]), .rd_uart(rd[0]),
    .wr_valid(wv[0]), .wr_ready(wrdy[0]), .wr_addr(wa[0]), .wr_data(wd0), .clear(clr[0]),
    .done(dn[0]), .overflow(ovf[0]), .frame_err(ferr[0]));
  uart_word_loader #(.BYTES_PER_WORD(4), .FIRST_BYTE_LSB(0)) u1 (
    .clk(clk), .rst_n(rst_n), .rx_empty(rx_empty[1]), .rx_data(rx_data[1]), .rd_uart(rd[1]),
    .wr_valid(wv[1]), .wr_ready(wrdy[1]), .wr_addr(wa[1]), .wr_data(wd1), .clear(clr[1]),
    .done(dn[1]), .overflow(ovf[1]), .frame_err(ferr[1]));
  uart_word_loader #(.BASE_ADDR(8'hFF), .WORD_COUNT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .rx_empty(rx_empty[2]), .rx_data(rx_data[2]), .rd_uart(rd[2]),
    .wr_valid(wv[2]), .wr_ready(wrdy[2]), .wr_addr(wa[2]), .wr_data(wd2), .clear(clr[2]),
    .done(dn[2]), .overflow(ovf[2]), .frame_err(ferr[2]));
  uart_word_loader #(.TIMEOUT_CYCLES(16)) u3 (
    .clk(clk), .rst_n(rst_n), .rx_empty(rx_empty[3]), .rx_data(rx_data[3]), .rd_uart(rd[3]),
    .wr_valid(wv[3]), .wr_ready(wrdy[3]), .wr_addr(wa[3]), .wr_data(wd3), .clear(clr[3]),
    .done(dn[3]), .overflow(ovf[3]), .frame_err(ferr[3]));

  function automatic int bpw(int i);
    return (i == 1) ? 4 : 2;
  endfunction
  function automatic logic [7:0] base(int i);
    return (i == 2) ? 8'hFF : 8'h00;
  endfunction
  function automatic int wc(int i);
    return (i == 2) ? 2 : 256;
  endfunction
  function automatic logic [63:0] get_wd(int i);
    case (i)
      0: return {48'h0, wd0};
      1: return {32'h0, wd1};
      2: return {48'h0, wd2};
      default: return {48'h0, wd3};
    endcase
  endfunction

  task automatic check(string name, logic [79:0] act, logic [79:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset(int i);
    m_addr[i] = base(i);
    m_acc[i] = '0;
    m_n[i] = 0;
    m_words[i] = 0;
  endtask

  // Byte stream -> expected (addr, word) list; bytes beyond the load are overflow.
  task automatic send(int i, logic [7:0] b);
    int s;
    fifo[i].push_back(b);
    if (m_words[i] < wc(i)) begin
      s = (i == 1) ? bpw(i) - 1 - m_n[i] : m_n[i];
      m_acc[i] = m_acc[i] | (64'(b) << (8 * s));
      m_n[i]++;
      if (m_n[i] == bpw(i)) begin
        exp_q[i].push_back({m_addr[i], m_acc[i]});
        m_addr[i] = m_addr[i] + 8'd1;
        m_words[i]++;
        m_n[i] = 0;
        m_acc[i] = '0;
      end
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) begin
      @(negedge clk);
      #3;
    end
  endtask

  task automatic settle(int i, int maxc);
    int c = 0;
    while ((fifo[i].size() != 0 || exp_q[i].size() != 0) && c < maxc) begin
      step();
      c++;
    end
    check($sformatf("drain%0d", i), 80'(fifo[i].size() + exp_q[i].size()), 80'd0);
  endtask

  task automatic wait_pop(int i);
    int p = pops[i];
    int c = 0;
    while (pops[i] == p && c < 20) begin
      step();
      c++;
    end
    check($sformatf("pop_seen%0d", i), 80'(pops[i] != p), 80'd1);
  endtask

  // RX FIFO model: a pop strobed before a rising edge is retired at the following negedge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (will_pop[i] && fifo[i].size() > 0) begin
        fifo[i].delete(0);
        pops[i]++;
      end
      rx_empty[i] = (fifo[i].size() == 0);
      rx_data[i] = rx_empty[i] ? 8'h00 : fifo[i][0];
    end
    #4;
    will_pop = rst_n ? rd : 4'b0;
  end

  always @(negedge clk) begin
    #4;
    for (int i = 0; i < 4; i++) begin
      if (rst_n) begin
        if (wv[i]) check($sformatf("rd_in_write%0d", i), 80'(rd[i]), 80'd0);
        if (pstall[i])
          check($sformatf("hold%0d", i), 80'({wv[i], wa[i], get_wd(i)}), 80'({1'b1, pa[i], pd[i]}));
        if (wv[i] && wrdy[i] && !clr[i]) begin
          if (exp_q[i].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write%0d: got %0h, expected no write", i, {wa[i], get_wd(i)});
          end else begin
            check($sformatf("write%0d", i), 80'({wa[i], get_wd(i)}), 80'(exp_q[i][0]));
            exp_q[i].delete(0);
          end
          got_q[i].push_back({wa[i], get_wd(i)});
        end
        if (ferr[i]) ferr_cnt[i]++;
      end
      pstall[i] = rst_n && wv[i] && !wrdy[i] && !clr[i];
      pa[i] = wa[i];
      pd[i] = get_wd(i);
    end
  end

  initial begin
    rx_empty = '1;
    wrdy = '1;
    clr = '0;
    will_pop = '0;
    pstall = '0;
    for (int i = 0; i < 4; i++) begin
      rx_data[i] = 8'h00;
      ferr_cnt[i] = 0;
      pops[i] = 0;
      model_reset(i);
    end
    step(2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset_ctl%0d", i), 80'({wv[i], dn[i], ovf[i], ferr[i], rd[i]}), 80'd0);
      check($sformatf("reset_addr%0d", i), 80'(wa[i]), 80'(base(i)));
      check($sformatf("reset_data%0d", i), 80'(get_wd(i)), 80'd0);
    end
    rst_n = 1'b1;
    step(2);

    // little-endian 16-bit words
    send(0, 8'h34); send(0, 8'h12); send(0, 8'h78); send(0, 8'h56);
    settle(0, 50);
    check("t1_w0", 80'(got_q[0][0]), 80'({8'h00, 64'h1234}));
    check("t1_w1", 80'(got_q[0][1]), 80'({8'h01, 64'h5678}));
    check("t1_done", 80'(dn[0]), 80'd0);

    // big-endian 32-bit word
    send(1, 8'hDE); send(1, 8'hAD); send(1, 8'hBE); send(1, 8'hEF);
    settle(1, 50);
    check("t2_w0", 80'(got_q[1][0]), 80'({8'h00, 64'hDEADBEEF}));

    // backpressure
    wrdy[0] = 1'b0;
    for (int b = 1; b <= 6; b++) send(0, 8'(b));
    step(12);
    check("t3_stall", 80'({wv[0], rd[0], wa[0], wd0}), 80'({1'b1, 1'b0, 8'h02, 16'h0201}));
    check("t3_fifo", 80'(fifo[0].size()), 80'd4);
    wrdy[0] = 1'b1;
    settle(0, 50);
    check("t3_w2", 80'(got_q[0][2]), 80'({8'h02, 64'h0201}));
    check("t3_w3", 80'(got_q[0][3]), 80'({8'h03, 64'h0403}));
    check("t3_w4", 80'(got_q[0][4]), 80'({8'h04, 64'h0605}));

    // wrapping short load, overflow, clear
    send(2, 8'h11); send(2, 8'h22); send(2, 8'h33);
    send(2, 8'h44); send(2, 8'h55); send(2, 8'h66);
    settle(2, 50);
    step(2);
    check("t4_w0", 80'(got_q[2][0]), 80'({8'hFF, 64'h2211}));
    check("t4_w1", 80'(got_q[2][1]), 80'({8'h00, 64'h4433}));
    check("t4_done", 80'({dn[2], ovf[2], wa[2]}), 80'({1'b1, 1'b1, 8'h00}));
    clr[2] = 1'b1;
    step();
    clr[2] = 1'b0;
    model_reset(2);
    step();
    check("t4_clear", 80'({dn[2], ovf[2], wa[2]}), 80'({1'b0, 1'b0, 8'hFF}));

    // timeout drops a lone byte; a 15-cycle gap is tolerated
    send(3, 8'hA1);
    wait_pop(3);
    step(20);
    check("t5_ferr", 80'(ferr_cnt[3]), 80'd1);
    m_n[3] = 0;
    m_acc[3] = '0;
    send(3, 8'hB2); send(3, 8'hC3);
    settle(3, 50);
    check("t5_w0", 80'(got_q[3][0]), 80'({8'h00, 64'hC3B2}));
    send(3, 8'hD4);
    wait_pop(3);
    step(14);
    send(3, 8'hE5);
    settle(3, 50);
    check("t5_gap", 80'(ferr_cnt[3]), 80'd1);
    check("t5_w1", 80'(got_q[3][1]), 80'({8'h01, 64'hE5D4}));
    for (int i = 0; i < 3; i++) check($sformatf("no_ferr%0d", i), 80'(ferr_cnt[i]), 80'd0);

    // asynchronous reset in the middle of a stalled write
    wrdy[0] = 1'b0;
    send(0, 8'h77); send(0, 8'h88);
    begin
      int c = 0;
      while (!wv[0] && c < 20) begin
        step();
        c++;
      end
    end
    check("t6_wv", 80'(wv[0]), 80'd1);
    rst_n = 1'b0;
    #1;
    check("t6_ctl", 80'({wv[0], dn[0], ovf[0], ferr[0], rd[0]}), 80'd0);
    check("t6_addr", 80'({wa[0], wd0}), 80'd0);
    check("t6_addr2", 80'(wa[2]), 80'(8'hFF));
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      model_reset(i);
    end
    step(2);
    rst_n = 1'b1;
    wrdy = '1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
